bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 167 ++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter
//
// Purpose: converts a WIDTH-bit binary operand into DIGITS packed BCD digits,
// one bit per clock. The result saturates to all nines with an overflow flag
// when it does not fit in DIGITS digits.
//
// Parameters:
//   WIDTH    binary input width (1..32)
//   DIGITS   number of BCD output digits (1..10)
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   start     conversion request, accepted only when idle
//   bin       binary operand, captured when start is accepted
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd/overflow are updated
//   bcd       packed result, digit 0 in bits [3:0]
//   overflow  last committed result exceeded 10^DIGITS-1
//   hex       active-low seven-segment codes (gfedcba), digit 0 in [6:0];
//             present only when the SEG_DECODE_EN macro is defined
module bin2bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef SEG_DECODE_EN
    ,
    output logic [7*DIGITS-1:0]   hex
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   work_q, work_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovfw_q, ovfw_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic [BW-1:0]   adj;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            ovfw_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            ovfw_q  <= ovfw_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Add-3 correction applied to the working digits before every shift.
    always_comb begin
        adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        ovfw_d  = ovfw_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d  = bin;
                    work_d  = '0;
                    ovfw_d  = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = {adj[BW-2:0], opnd_q[WIDTH-1]};
                opnd_d = opnd_q << 1;
                cnt_d  = cnt_q - 1'b1;
                // A one leaving the top digit means the value no longer fits.
                if (adj[BW-1]) begin
                    ovfw_d = 1'b1;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                bcd_d   = ovfw_q ? NINES : work_q;
                ovf_d   = ovfw_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

`ifdef SEG_DECODE_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            4'd15:   seg7 = 7'b0111111;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // On overflow every digit shows a dash instead of the saturated nines.
    always_comb begin
        hex = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hex[i*7 +: 7] = ovf_q ? seg7(4'hF) : seg7(bcd_q[i*4 +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  bin;

    logic        busy_a, done_a, ovf_a;
    logic [15:0] bcd_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
`ifdef SEG_DECODE_EN
    logic [27:0] hex_a;
    logic [13:0] hex_b;
`endif

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy_a),
        .done     (done_a),
        .bcd      (bcd_a),
        .overflow (ovf_a)
`ifdef SEG_DECODE_EN
        ,
        .hex      (hex_a)
`endif
    );

    bin2bcd_seq #(.WIDTH(10), .DIGITS(2)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy_b),
        .done     (done_b),
        .bcd      (bcd_b),
        .overflow (ovf_b)
`ifdef SEG_DECODE_EN
        ,
        .hex      (hex_b)
`endif
    );

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Caller is just after a falling edge. Drives one request, optionally
    // pulses start again on edge glitch_k, and scores the result.
    task automatic run_conv(input logic [9:0] v, input logic [15:0] eb,
                            input logic eo, input int glitch_k);
        exp_t e;
        int   lat;
        int   extra;
        e.bcd = eb;
        e.ovf = eo;
        sb.push_back(e);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = 10'($urandom);
        check("busy_after_accept", busy_a, 1);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (k == glitch_k) begin
                start = 1'b1;
                bin   = 10'd77;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done_a) lat = k;
        end
        check("latency", lat, 11);
        if (sb.size() > 0) e = sb.pop_front();
        if (lat != 0) begin
            check("bcd", bcd_a, e.bcd);
            check("overflow", ovf_a, e.ovf);
            check("busy_at_done", busy_a, 0);
        end
        extra = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) extra++;
        end
        check("no_extra_done", extra, 0);
        check("bcd_hold", bcd_a, e.bcd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        vecs[0] = '{10'd25,   16'h0025, 1'b0};
        vecs[1] = '{10'd89,   16'h0089, 1'b0};
        vecs[2] = '{10'd14,   16'h0014, 1'b0};
        vecs[3] = '{10'd84,   16'h0084, 1'b0};
        vecs[4] = '{10'd1023, 16'h1023, 1'b0};
        vecs[5] = '{10'd0,    16'h0000, 1'b0};
        vecs[6] = '{10'd999,  16'h0999, 1'b0};
        vecs[7] = '{10'd1,    16'h0001, 1'b0};
        vecs[8] = '{10'd512,  16'h0512, 1'b0};
        vecs[9] = '{10'd89,   16'h0089, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_bcd", bcd_a, 0);
        check("reset_ovf", ovf_a, 0);
        reset = 1'b0;

        // Start is already high for the first edge after reset release.
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, 0);
        end
`ifdef SEG_DECODE_EN
        check("hex_89", hex_a, {7'b1000000, 7'b1000000, 7'b0000000, 7'b0010000});
`endif

        // Second request during SHIFT must be dropped.
        run_conv(10'd25, 16'h0025, 1'b0, 4);

        // Two-digit instance saturates while the four-digit one does not.
        run_conv(10'd100, 16'h0100, 1'b0, 0);
        check("b_bcd_sat", bcd_b, 8'h99);
        check("b_ovf", ovf_b, 1);
`ifdef SEG_DECODE_EN
        check("b_hex_dash", hex_b, 14'b0111111_0111111);
`endif
        run_conv(10'd42, 16'h0042, 1'b0, 0);
        check("b_bcd_fit", bcd_b, 8'h42);
        check("b_ovf_clear", ovf_b, 0);

        // Reset in the middle of a conversion.
        start = 1'b1;
        bin   = 10'd89;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_bcd", bcd_a, 0);
        check("abort_done", done_a, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) nd++;
        end
        check("abort_no_done", nd, 0);
        check("abort_bcd_hold", bcd_a, 0);
        run_conv(10'd14, 16'h0014, 1'b0, 0);

        // Start coincident with reset release.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_conv(10'd84, 16'h0084, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
